// File: rtl/snake_step_sequencer.sv
// Game-step controller for a snake game: sequences move/check/grow per tick,
// tracks committed direction, length and score, and flags dropped ticks.
module snake_step_sequencer #(
    parameter int MAX_LEN  = 20,
    parameter int INIT_LEN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       hit_body,
    input  logic       hit_apple,
    output logic [1:0] dir,
    output logic       restart,
    output logic       move_en,
    output logic       grow_en,
    output logic       apple_reloc,
    output logic [5:0] length,
    output logic [7:0] score,
    output logic       running,
    output logic       game_over,
    output logic       tick_miss
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_MOVE,
        S_CHECK,
        S_GROW,
        S_OVER
    } state_t;

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_L = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    localparam logic [5:0] MAX_L  = 6'(MAX_LEN);
    localparam logic [5:0] INIT_L = 6'(INIT_LEN);

    state_t      state_q;
    logic [1:0]  dir_q;
    logic [1:0]  pending_q;
    logic [1:0]  pending_d;
    logic [1:0]  dir_commit;
    logic [5:0]  length_q;
    logic [7:0]  score_q;
    logic        restart_q;
    logic        move_en_q;
    logic        grow_en_q;
    logic        apple_reloc_q;
    logic        running_q;
    logic        game_over_q;
    logic        tick_miss_q;
    logic        start_prev_q;
    logic        restart_go;
    logic        in_step;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reversal is judged against the direction that will be in force after
    // this edge, so a press coinciding with a tick cannot queue a U-turn.
    always_comb begin
        dir_commit = (state_q == S_WAIT_TICK && tick) ? pending_q : dir_q;
        pending_d  = pending_q;
        if (down  && dir_commit != DIR_U) pending_d = DIR_D;
        if (up    && dir_commit != DIR_D) pending_d = DIR_U;
        if (left  && dir_commit != DIR_R) pending_d = DIR_L;
        if (right && dir_commit != DIR_L) pending_d = DIR_R;
    end

    assign restart_go = (state_q == S_IDLE && start) ||
                        (state_q == S_OVER && start && !start_prev_q);
    assign in_step    = (state_q == S_MOVE) || (state_q == S_CHECK) || (state_q == S_GROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dir_q         <= DIR_R;
            pending_q     <= DIR_R;
            length_q      <= INIT_L;
            score_q       <= '0;
            restart_q     <= 1'b0;
            move_en_q     <= 1'b0;
            grow_en_q     <= 1'b0;
            apple_reloc_q <= 1'b0;
            running_q     <= 1'b0;
            game_over_q   <= 1'b0;
            tick_miss_q   <= 1'b0;
            start_prev_q  <= 1'b0;
        end else begin
            start_prev_q  <= start;
            restart_q     <= 1'b0;
            move_en_q     <= 1'b0;
            grow_en_q     <= 1'b0;
            apple_reloc_q <= 1'b0;
            if (in_step && tick) tick_miss_q <= 1'b1;

            case (state_q)
                S_IDLE, S_OVER: begin
                    if (restart_go) begin
                        state_q     <= S_WAIT_TICK;
                        restart_q   <= 1'b1;
                        length_q    <= INIT_L;
                        score_q     <= '0;
                        dir_q       <= DIR_R;
                        pending_q   <= DIR_R;
                        tick_miss_q <= 1'b0;
                        running_q   <= 1'b1;
                        game_over_q <= 1'b0;
                    end
                end
                S_WAIT_TICK: begin
                    pending_q <= pending_d;
                    if (tick) begin
                        state_q   <= S_MOVE;
                        dir_q     <= pending_q;
                        move_en_q <= 1'b1;
                    end
                end
                S_MOVE: begin
                    pending_q <= pending_d;
                    state_q   <= S_CHECK;
                end
                S_CHECK: begin
                    pending_q <= pending_d;
                    if (hit_body) begin
                        state_q     <= S_OVER;
                        running_q   <= 1'b0;
                        game_over_q <= 1'b1;
                    end else if (hit_apple) begin
                        state_q       <= S_GROW;
                        apple_reloc_q <= 1'b1;
                        score_q       <= sat_inc8(score_q);
                        if (length_q < MAX_L) begin
                            grow_en_q <= 1'b1;
                            length_q  <= length_q + 6'd1;
                        end
                    end else begin
                        state_q <= S_WAIT_TICK;
                    end
                end
                S_GROW: begin
                    pending_q <= pending_d;
                    state_q   <= S_WAIT_TICK;
                end
                default: begin
                    state_q     <= S_IDLE;
                    running_q   <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign dir         = dir_q;
    assign restart     = restart_q;
    assign move_en     = move_en_q;
    assign grow_en     = grow_en_q;
    assign apple_reloc = apple_reloc_q;
    assign length      = length_q;
    assign score       = score_q;
    assign running     = running_q;
    assign game_over   = game_over_q;
    assign tick_miss   = tick_miss_q;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Directed bench for snake_step_sequencer (MAX_LEN=4 so the length cap is reachable).
module tb_snake_step_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, start = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       hit_body = 1'b0, hit_apple = 1'b0;
    logic [1:0] dir;
    logic       restart, move_en, grow_en, apple_reloc;
    logic [5:0] length;
    logic [7:0] score;
    logic       running, game_over, tick_miss;

    int n_chk  = 0;
    int n_fail = 0;
    int n_move = 0, n_restart = 0, n_grow = 0, n_reloc = 0;
    int base_move, base_restart, base_grow, base_reloc;

    snake_step_sequencer #(.MAX_LEN(4), .INIT_LEN(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .up(up), .down(down), .left(left), .right(right),
        .hit_body(hit_body), .hit_apple(hit_apple),
        .dir(dir), .restart(restart), .move_en(move_en), .grow_en(grow_en),
        .apple_reloc(apple_reloc), .length(length), .score(score),
        .running(running), .game_over(game_over), .tick_miss(tick_miss)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (move_en)     n_move++;
        if (restart)     n_restart++;
        if (grow_en)     n_grow++;
        if (apple_reloc) n_reloc++;
        if ((int'(restart) + int'(move_en) + int'(apple_reloc)) > 1) begin
            n_chk++;
            n_fail++;
            $display("FAIL pulse_excl: got %0d pulses together, expected at most 1",
                     int'(restart) + int'(move_en) + int'(apple_reloc));
        end
    end

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Tick -> MOVE (checked), hits applied for CHECK; returns one cycle after CHECK.
    task automatic step(input logic [1:0] exp_dir, input logic ha, input logic hb, input string tag);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk({tag, "_move_en"}, move_en, 1);
        chk({tag, "_dir"}, dir, exp_dir);
        hit_apple = ha;
        hit_body  = hb;
        cyc();
        chk({tag, "_move_off"}, move_en, 0);
        cyc();
        hit_apple = 1'b0;
        hit_body  = 1'b0;
    endtask

    initial begin
        // Async reset before any clock edge
        #2 rst = 1'b1;
        #2;
        chk("rst_running", running, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_length", length, 1);
        chk("rst_score", score, 0);
        chk("rst_dir", dir, 0);
        chk("rst_pulses", {restart, move_en, grow_en, apple_reloc, tick_miss}, 0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("idle_running", running, 0);

        // Start and three plain steps
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_restart", restart, 1);
        chk("start_running", running, 1);
        cyc();
        chk("restart_one_cycle", restart, 0);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, 1'b0, "plain");
            chk("plain_grow", grow_en, 0);
            chk("plain_reloc", apple_reloc, 0);
        end
        chk("plain_moves", n_move, 3);
        chk("plain_restarts", n_restart, 1);
        chk("plain_length", length, 1);
        chk("plain_score", score, 0);
        chk("plain_dir", dir, 0);

        // Direction capture: reversal ignored, up taken
        left = 1'b1;
        cyc();
        left = 1'b0;
        up = 1'b1;
        cyc();
        up = 1'b0;
        step(2'b10, 1'b0, 1'b0, "turn_up");
        down = 1'b1;
        cyc();
        down = 1'b0;
        step(2'b10, 1'b0, 1'b0, "rev_down");
        chk("rev_down_dir", dir, 2'b10);

        // Apples: three grow, fourth capped at MAX_LEN
        for (int i = 1; i <= 3; i++) begin
            step(2'b10, 1'b1, 1'b0, "apple");
            chk("apple_grow", grow_en, 1);
            chk("apple_reloc", apple_reloc, 1);
            chk("apple_length", length, 1 + i);
            chk("apple_score", score, i);
            cyc();
            chk("apple_grow_off", grow_en, 0);
        end
        step(2'b10, 1'b1, 1'b0, "cap");
        chk("cap_grow", grow_en, 0);
        chk("cap_reloc", apple_reloc, 1);
        chk("cap_length", length, 4);
        chk("cap_score", score, 4);
        cyc();

        // Tick during MOVE is dropped and flagged
        base_move = n_move;
        chk("miss_clear", tick_miss, 0);
        tick = 1'b1;
        cyc();
        chk("miss_move_en", move_en, 1);
        cyc();
        tick = 1'b0;
        chk("miss_flag", tick_miss, 1);
        cyc();
        cyc();
        cyc();
        chk("miss_one_move", n_move - base_move, 1);
        chk("miss_sticky", tick_miss, 1);

        // Body hit wins over apple; start held across OVER entry
        base_grow    = n_grow;
        base_restart = n_restart;
        start = 1'b1;
        step(2'b10, 1'b1, 1'b1, "body");
        chk("over_game_over", game_over, 1);
        chk("over_running", running, 0);
        chk("over_grow", n_grow - base_grow, 0);
        base_move = n_move;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        chk("over_no_move", n_move - base_move, 0);
        chk("over_held_start", n_restart - base_restart, 0);
        chk("over_dir_hold", dir, 2'b10);
        chk("over_length_hold", length, 4);
        chk("over_score_hold", score, 4);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("over_restart", restart, 1);
        chk("over_restart_len", length, 1);
        chk("over_restart_score", score, 0);
        chk("over_restart_dir", dir, 0);
        chk("over_restart_miss", tick_miss, 0);
        chk("over_restart_go", game_over, 0);
        cyc();

        // One grow, then reset in CHECK with an apple present
        step(2'b00, 1'b1, 1'b0, "pre_rst");
        chk("pre_rst_length", length, 2);
        cyc();
        base_grow  = n_grow;
        base_reloc = n_reloc;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        hit_apple = 1'b1;
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("midrst_length", length, 1);
        chk("midrst_running", running, 0);
        chk("midrst_score", score, 0);
        cyc();
        cyc();
        hit_apple = 1'b0;
        rst = 1'b0;
        cyc();
        chk("midrst_no_grow", n_grow - base_grow, 0);
        chk("midrst_no_reloc", n_reloc - base_reloc, 0);
        chk("midrst_idle", {running, game_over}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_step_sequencer.md
SNAKE_STEP_SEQUENCER -- requirements
Module: snake_step_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 20, maximum snake length in segments including the head (2..63).
REQ-002 SHALL have parameter INIT_LEN, default 1, length loaded on every restart (1..MAX_LEN).
REQ-003 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 tick  input  1  one-cycle game-step pulse from the slow-rate divider.
REQ-006 start  input  1  level; requests a new game.
REQ-007 up, down, left, right  input  1 each  level button inputs, already debounced.
REQ-008 hit_body  input  1  datapath flag: head overlaps a body segment; valid in the CHECK state.
REQ-009 hit_apple  input  1  datapath flag: head overlaps the apple; valid in the CHECK state.
REQ-010 dir  output  2  committed direction: 00 right, 01 left, 10 up, 11 down.
REQ-011 restart  output  1  one-cycle pulse; datapath reloads the head at centre and clears the body.
REQ-012 move_en  output  1  one-cycle pulse; datapath advances the head by one step in dir and shifts the body.
REQ-013 grow_en  output  1  one-cycle pulse; datapath appends one segment.
REQ-014 apple_reloc  output  1  one-cycle pulse; datapath relocates the apple.
REQ-015 length  output  6  current snake length.
REQ-016 score  output  8  apples eaten.
REQ-017 running  output  1  high in the WAIT_TICK, MOVE, CHECK and GROW states.
REQ-018 game_over  output  1  high in the OVER state.
REQ-019 tick_miss  output  1  sticky flag: a tick arrived while a step was in progress.

Function
REQ-020 SHALL implement an FSM with states IDLE, WAIT_TICK, MOVE, CHECK, GROW and OVER; all outputs SHALL be registered.
REQ-021 IDLE: start=1 SHALL pulse restart, load length=INIT_LEN, score=0, dir=00, pending=00 and tick_miss=0, then go to WAIT_TICK.
REQ-022 Direction capture, every cycle while running: the pressed button with highest priority (right > left > up > down) SHALL be stored in pending; a button that reverses the committed dir SHALL be ignored.
REQ-023 WAIT_TICK: tick=1 SHALL go to MOVE; otherwise the FSM SHALL stay in WAIT_TICK.
REQ-024 MOVE: SHALL load dir<=pending and assert move_en for exactly one cycle (the first cycle move_en is seen high carries the new dir), then go to CHECK.
REQ-025 CHECK: SHALL sample the hit inputs in the cycle after move_en.
  - hit_body=1: go to OVER (this takes priority over hit_apple).
  - hit_apple=1 otherwise: go to GROW.
  - neither: go to WAIT_TICK.
REQ-026 GROW (one cycle): SHALL pulse apple_reloc and set score=min(score+1,255).
  - length<MAX_LEN: also pulse grow_en and increment length.
  - length==MAX_LEN: grow_en stays 0 and length holds.
  - Then go to WAIT_TICK.
REQ-027 A tick during MOVE, CHECK or GROW SHALL be dropped and SHALL set tick_miss; a step SHALL never be queued.
REQ-028 OVER: dir, length and score SHALL hold; no pulses SHALL be issued. A start that rises (was 0 the previous cycle) SHALL behave as REQ-021 and go to WAIT_TICK.
REQ-029 start held high through OVER entry SHALL NOT restart the game; a new 0->1 edge is required.
REQ-030 In every state other than IDLE and OVER, start SHALL be ignored.
REQ-031 At most one of restart, move_en and apple_reloc SHALL be high in any cycle.

Reset
REQ-032 rst=1 SHALL, without waiting for clk, force state=IDLE, dir=00, pending=00, length=INIT_LEN, score=0, tick_miss=0, and restart, move_en, grow_en, apple_reloc, running and game_over all 0.
REQ-033 rst asserted mid-step (MOVE, CHECK or GROW) SHALL abort the step with no pulse issued after the rst edge.

Verification
REQ-034 Reset, start pulse, 3 ticks with no hits -> one restart, then 3 move_en pulses each 1 cycle after its tick; length=1, score=0, dir=00.
REQ-035 While dir=00: press left, then up before the next tick -> left ignored; next move_en has dir=10; then press down -> ignored, dir stays 10.
REQ-036 hit_apple=1 in CHECK, 3 times -> grow_en and apple_reloc pulse 2 cycles after each move_en; length=4, score=3. With MAX_LEN=4, a 4th apple -> apple_reloc only; length=4, score=4.
REQ-037 hit_body=1 and hit_apple=1 together in CHECK -> OVER, game_over=1, no grow_en; further ticks cause no move_en; start held -> no restart; start released then pressed -> restart, length=INIT_LEN.
REQ-038 tick asserted in the cycle the FSM is in MOVE -> tick_miss=1 and only one move_en results.
REQ-039 rst asserted in CHECK with hit_apple=1 -> no grow_en or apple_reloc; state IDLE, length=INIT_LEN.
